// File: rtl/execute_cycle_if.sv
// execute_cycle_if: ID/EX inputs and EX/MEM outputs of the execute stage.
// The master side is the pipeline around EX; the slave side is the EX stage.
interface execute_cycle_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // ID/EX register contents
    logic              RegwriteE;
    logic              ALUsrcE;
    logic              MemwriteE;
    logic              ResultsrcE;
    logic              BranchE;
    logic [2:0]        ALUcontrolE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCplus4E;
    logic [XLEN-1:0]   ImmextE;
    logic [REG_AW-1:0] RdE;

    // Hazard unit selects and the WB forward source
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [XLEN-1:0]   ResultW;

    // Redirect back to fetch
    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;

    // EX/MEM register contents
    logic              RegwriteM;
    logic              MemwriteM;
    logic              ResultsrcM;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   WriteDataM;
    logic [REG_AW-1:0] RdM;
    logic [XLEN-1:0]   PCplus4M;

    modport master (
        output RegwriteE, ALUsrcE, MemwriteE, ResultsrcE, BranchE, ALUcontrolE,
        output RD1E, RD2E, PCE, PCplus4E, ImmextE, RdE,
        output ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE,
        input  RegwriteM, MemwriteM, ResultsrcM, ALUResultM, WriteDataM, RdM, PCplus4M
    );

    modport slave (
        input  RegwriteE, ALUsrcE, MemwriteE, ResultsrcE, BranchE, ALUcontrolE,
        input  RD1E, RD2E, PCE, PCplus4E, ImmextE, RdE,
        input  ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE,
        output RegwriteM, MemwriteM, ResultsrcM, ALUResultM, WriteDataM, RdM, PCplus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the 5-stage RV32I pipeline.
// Forwarded operand selection, ALU, beq resolution and the EX/MEM register.
module execute_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    execute_cycle_if.slave    bus
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_ZERO = 3'b111
    } alu_op_e;

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_write_data_e;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_zero;

    logic              r_regwrite_m;
    logic              r_memwrite_m;
    logic              r_resultsrc_m;
    logic [XLEN-1:0]   r_alu_result_m;
    logic [XLEN-1:0]   r_write_data_m;
    logic [REG_AW-1:0] r_rd_m;
    logic [XLEN-1:0]   r_pcplus4_m;

    // The MEM forward path reads r_alu_result_m before this edge updates it,
    // so it always carries the previous instruction's result.
    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // signal; a missing assignment in always_comb would infer a latch.
        w_src_a = bus.RD1E;
        case (fwd_sel_e'(bus.ForwardAE))
            FWD_WB:  w_src_a = bus.ResultW;
            FWD_MEM: w_src_a = r_alu_result_m;
            default: w_src_a = bus.RD1E;
        endcase
    end

    always_comb begin
        w_write_data_e = bus.RD2E;
        case (fwd_sel_e'(bus.ForwardBE))
            FWD_WB:  w_write_data_e = bus.ResultW;
            FWD_MEM: w_write_data_e = r_alu_result_m;
            default: w_write_data_e = bus.RD2E;
        endcase
    end

    assign w_src_b = bus.ALUsrcE ? bus.ImmextE : w_write_data_e;

    // add/sub wrap naturally at XLEN bits; carry and overflow are not kept.
    always_comb begin
        w_alu_result = '0;
        case (alu_op_e'(bus.ALUcontrolE))
            ALU_ADD:  w_alu_result = w_src_a + w_src_b;
            ALU_SUB:  w_alu_result = w_src_a - w_src_b;
            ALU_AND:  w_alu_result = w_src_a & w_src_b;
            ALU_OR:   w_alu_result = w_src_a | w_src_b;
            ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
            ALU_SLL:  w_alu_result = w_src_a << w_src_b[SHAMT_W-1:0];
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}},
                                      ($signed(w_src_a) < $signed(w_src_b))};
            default:  w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    // Reset masks the redirect so a stale beq in EX cannot steer fetch.
    assign bus.PCSrcE    = bus.BranchE & w_zero & ~rst;
    assign bus.PCTargetE = bus.PCE + bus.ImmextE;

    // EX/MEM register: reset turns the slot into a bubble (no write, no store).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, matching real flops.
        if (rst) begin
            r_regwrite_m   <= 1'b0;
            r_memwrite_m   <= 1'b0;
            r_resultsrc_m  <= 1'b0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_rd_m         <= '0;
            r_pcplus4_m    <= '0;
        end else begin
            r_regwrite_m   <= bus.RegwriteE;
            r_memwrite_m   <= bus.MemwriteE;
            r_resultsrc_m  <= bus.ResultsrcE;
            r_alu_result_m <= w_alu_result;
            r_write_data_m <= w_write_data_e;
            r_rd_m         <= bus.RdE;
            r_pcplus4_m    <= bus.PCplus4E;
        end
    end

    assign bus.RegwriteM  = r_regwrite_m;
    assign bus.MemwriteM  = r_memwrite_m;
    assign bus.ResultsrcM = r_resultsrc_m;
    assign bus.ALUResultM = r_alu_result_m;
    assign bus.WriteDataM = r_write_data_m;
    assign bus.RdM        = r_rd_m;
    assign bus.PCplus4M   = r_pcplus4_m;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: scoreboard bench for the EX stage; directed cases then
// randomized traffic against an arithmetic reference model.
module tb_execute_cycle;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct {
        logic        rst;
        logic        regwrite;
        logic        alusrc;
        logic        memwrite;
        logic        resultsrc;
        logic        branch;
        logic [2:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pce;
        logic [31:0] pcplus4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] resultw;
    } stim_t;

    typedef struct {
        logic        pcsrc;
        logic [31:0] pctarget;
        logic        regwrite;
        logic        memwrite;
        logic        resultsrc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pcplus4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    execute_cycle_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    execute_cycle #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] model_alu_m  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb_v;
        sa   = int'(a);
        sb_v = int'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << (b % 32);
            3'd5:    return (sa < sb_v) ? 32'd1 : 32'd0;
            3'd6:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst       = ($urandom_range(0, 31) == 0);
        s.regwrite  = 1'($urandom);
        s.alusrc    = 1'($urandom);
        s.memwrite  = 1'($urandom);
        s.resultsrc = 1'($urandom);
        s.branch    = 1'($urandom);
        s.op        = 3'($urandom_range(0, 7));
        s.rd1       = $urandom;
        s.rd2       = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
        s.pce       = $urandom;
        s.pcplus4   = s.pce + 32'd4;
        s.imm       = $urandom;
        s.rd        = 5'($urandom);
        s.fa        = 2'($urandom);
        s.fb        = 2'($urandom);
        s.resultw   = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
        return s;
    endfunction

    // Applies one instruction to EX and queues what the stage must produce.
    task automatic issue(input stim_t s);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] b;
        logic [31:0] r;
        @(negedge clk);
        rst             = s.rst;
        bus.RegwriteE   = s.regwrite;
        bus.ALUsrcE     = s.alusrc;
        bus.MemwriteE   = s.memwrite;
        bus.ResultsrcE  = s.resultsrc;
        bus.BranchE     = s.branch;
        bus.ALUcontrolE = s.op;
        bus.RD1E        = s.rd1;
        bus.RD2E        = s.rd2;
        bus.PCE         = s.pce;
        bus.PCplus4E    = s.pcplus4;
        bus.ImmextE     = s.imm;
        bus.RdE         = s.rd;
        bus.ForwardAE   = s.fa;
        bus.ForwardBE   = s.fb;
        bus.ResultW     = s.resultw;

        a  = pick(s.fa, s.rd1, s.resultw, model_alu_m);
        wd = pick(s.fb, s.rd2, s.resultw, model_alu_m);
        b  = s.alusrc ? s.imm : wd;
        r  = ref_alu(s.op, a, b);

        e.pcsrc    = !s.rst && s.branch && (r == 32'd0);
        e.pctarget = s.pce + s.imm;
        if (s.rst) begin
            e.regwrite  = 1'b0;
            e.memwrite  = 1'b0;
            e.resultsrc = 1'b0;
            e.alu       = 32'd0;
            e.wdata     = 32'd0;
            e.rd        = 5'd0;
            e.pcplus4   = 32'd0;
        end else begin
            e.regwrite  = s.regwrite;
            e.memwrite  = s.memwrite;
            e.resultsrc = s.resultsrc;
            e.alu       = r;
            e.wdata     = wd;
            e.rd        = s.rd;
            e.pcplus4   = s.pcplus4;
        end
        model_alu_m = e.alu;
        sb.push_back(e);
    endtask

    // Monitor: redirect outputs mid-cycle, then the EX/MEM register after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                e = sb[0];
                check("PCSrcE", 32'(bus.PCSrcE), 32'(e.pcsrc));
                check("PCTargetE", bus.PCTargetE, e.pctarget);
                @(posedge clk);
                #1;
                check("RegwriteM", 32'(bus.RegwriteM), 32'(e.regwrite));
                check("MemwriteM", 32'(bus.MemwriteM), 32'(e.memwrite));
                check("ResultsrcM", 32'(bus.ResultsrcM), 32'(e.resultsrc));
                check("ALUResultM", bus.ALUResultM, e.alu);
                check("WriteDataM", bus.WriteDataM, e.wdata);
                check("RdM", 32'(bus.RdM), 32'(e.rd));
                check("PCplus4M", bus.PCplus4M, e.pcplus4);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        bus.RegwriteE = 1'b0; bus.ALUsrcE = 1'b0; bus.MemwriteE = 1'b0;
        bus.ResultsrcE = 1'b0; bus.BranchE = 1'b0; bus.ALUcontrolE = 3'd0;
        bus.RD1E = '0; bus.RD2E = '0; bus.PCE = '0; bus.PCplus4E = '0;
        bus.ImmextE = '0; bus.RdE = '0; bus.ForwardAE = '0; bus.ForwardBE = '0;
        bus.ResultW = '0;

        // Reset for two cycles with a write and a would-be-taken beq pending.
        s = idle(); s.rst = 1'b1; s.regwrite = 1'b1; s.rd = 5'd5;
        s.branch = 1'b1; s.op = 3'd7;
        issue(s); issue(s);
        s.rst = 1'b0;
        issue(s);

        // ALU: add immediate, signed slt, shift amount uses low five bits.
        s = idle(); s.rd1 = 32'd7; s.imm = 32'hFFFF_FFFD; s.alusrc = 1'b1; s.op = 3'd0;
        issue(s);
        s = idle(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.op = 3'd5;
        issue(s);
        s = idle(); s.rd1 = 32'd1; s.rd2 = 32'd33; s.op = 3'd4;
        issue(s);

        // Forwarding from MEM (previous result) and from WB into store data.
        s = idle(); s.rd1 = 32'd4; s.rd2 = 32'd6; s.op = 3'd0;
        issue(s);
        s = idle(); s.fa = 2'b10; s.rd1 = 32'd0; s.rd2 = 32'd5; s.op = 3'd0;
        issue(s);
        s = idle(); s.fb = 2'b01; s.resultw = 32'd9; s.rd1 = 32'd1; s.rd2 = 32'd2;
        issue(s);

        // beq taken and not taken.
        s = idle(); s.branch = 1'b1; s.op = 3'd1; s.rd1 = 32'h20; s.rd2 = 32'h20;
        s.pce = 32'h100; s.imm = 32'hFFFF_FFF8;
        issue(s);
        s.rd2 = 32'h21;
        issue(s);

        // Store address/data path.
        s = idle(); s.memwrite = 1'b1; s.alusrc = 1'b1; s.rd1 = 32'h1000;
        s.imm = 32'd4; s.rd2 = 32'hDEAD; s.op = 3'd0;
        issue(s);

        // Wrap of the ALU add and the branch target adder.
        s = idle(); s.rd1 = 32'hFFFF_FFFF; s.imm = 32'd1; s.alusrc = 1'b1;
        issue(s);
        s = idle(); s.pce = 32'hFFFF_FFFC; s.imm = 32'd8;
        issue(s);

        // Mid-stream reset drops the instruction in EX.
        issue(rand_stim());
        s = rand_stim(); s.rst = 1'b1; s.branch = 1'b1; s.op = 3'd7;
        issue(s);

        for (int i = 0; i < 400; i++) issue(rand_stim());

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
